// File: rtl/petris_pkg.sv
// rtl/petris_pkg.sv - shared board geometry, piece/state types and score lookup
package petris_pkg;

    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int SCORE_W = 20;

    typedef logic [ROWS*COLS-1:0] board_t;

    typedef enum logic [2:0] {
        TET_I, TET_O, TET_T, TET_S, TET_Z, TET_J, TET_L
    } tetrimino_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_SCAN, ST_FILL, ST_DONE
    } lce_state_e;

    localparam logic [SCORE_W-1:0] SCORE_1 = 20'd40;
    localparam logic [SCORE_W-1:0] SCORE_2 = 20'd100;
    localparam logic [SCORE_W-1:0] SCORE_3 = 20'd300;
    localparam logic [SCORE_W-1:0] SCORE_4 = 20'd1200;

    function automatic logic [SCORE_W-1:0] score_lookup(input int unsigned lines);
        case (lines)
            0:       score_lookup = '0;
            1:       score_lookup = SCORE_1;
            2:       score_lookup = SCORE_2;
            3:       score_lookup = SCORE_3;
            default: score_lookup = SCORE_4;
        endcase
    endfunction

endpackage

// File: rtl/line_clear_score.sv
// rtl/line_clear_score.sv - registered saturating score accumulator
module line_clear_score
    import petris_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               add_en,
    input  logic [CNT_W-1:0]   lines,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;

    assign sum = {1'b0, score_q} + {1'b0, score_lookup(32'(lines))};

    always_comb begin
        score_d = score_q;
        if (add_en) begin
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - row-sequential full-line removal and compaction; PETRIS_SCORE_EN adds the score accumulator
module line_clear_engine #(
    parameter int COLS  = petris_pkg::COLS,
    parameter int ROWS  = petris_pkg::ROWS,
    parameter int CNT_W = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS-1:0]           board_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ROWS*COLS-1:0]           board_out,
    output logic [CNT_W-1:0]               lines_cleared,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [petris_pkg::SCORE_W-1:0] score
);
    import petris_pkg::*;

    localparam int PTR_W = $clog2(ROWS);

    lce_state_e             state_q, state_d;
    logic [ROWS*COLS-1:0]   b_q, b_d;
    logic [PTR_W-1:0]       rp_q, rp_d;
    logic [PTR_W-1:0]       wp_q, wp_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [COLS-1:0]        row_rd;
    logic                   row_full;

    assign row_rd   = b_q[int'(rp_q)*COLS +: COLS];
    assign row_full = &row_rd;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        n_d     = n_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    b_d     = board_in;
                    rp_d    = PTR_W'(ROWS-1);
                    wp_d    = PTR_W'(ROWS-1);
                    n_d     = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // wp trails rp by the number of full rows seen, so the copy never clobbers unread rows
                if (row_full) begin
                    n_d = n_q + CNT_W'(1);
                end else begin
                    b_d[int'(wp_q)*COLS +: COLS] = row_rd;
                    if (wp_q != '0) wp_d = wp_q - PTR_W'(1);
                end
                if (rp_q != '0) begin
                    rp_d = rp_q - PTR_W'(1);
                end else begin
                    state_d = (n_d != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                b_d[int'(wp_q)*COLS +: COLS] = '0;
                if (wp_q != '0) begin
                    wp_d = wp_q - PTR_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            rp_q    <= '0;
            wp_q    <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            n_q     <= n_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign board_out     = b_q;
    assign lines_cleared = n_q;

`ifdef PETRIS_SCORE_EN
    line_clear_score #(
        .CNT_W (CNT_W)
    ) u_score (
        .clk    (clk),
        .rst    (rst),
        .add_en (out_valid & out_ready),
        .lines  (n_q),
        .score  (score)
    );
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - directed bench with a queue-based compaction model and per-cycle compare
module tb_line_clear_engine;
    import petris_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    board_t              board_in = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    board_t              board_out;
    logic [4:0]          lines_cleared;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [SCORE_W-1:0]  score;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    line_clear_engine dut (
        .clk           (clk),
        .rst           (rst),
        .board_in      (board_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ROWS*COLS-1:0] act, input logic [ROWS*COLS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int model_count(input board_t b);
        int n = 0;
        for (int r = 0; r < ROWS; r++) if (b[r*COLS +: COLS] == {COLS{1'b1}}) n++;
        return n;
    endfunction

    // surviving rows keep their top-to-bottom order and settle against the floor
    function automatic board_t model_board(input board_t b);
        logic [COLS-1:0] keep[$];
        board_t res = '0;
        for (int r = 0; r < ROWS; r++)
            if (b[r*COLS +: COLS] != {COLS{1'b1}}) keep.push_back(b[r*COLS +: COLS]);
        for (int i = 0; i < keep.size(); i++)
            res[(ROWS - keep.size() + i)*COLS +: COLS] = keep[i];
        return res;
    endfunction

    function automatic int model_points(input int n);
`ifdef PETRIS_SCORE_EN
        case (n)
            0: return 0;
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
`else
        return n * 0;
`endif
    endfunction

    bit     m_idle = 1'b1;
    bit     m_done = 1'b0;
    int     m_rem = 0;
    board_t exp_board = '0;
    int     exp_n = 0;
    int     exp_score = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle <= 1'b1; m_done <= 1'b0; m_rem <= 0;
            exp_board <= '0; exp_n <= 0; exp_score <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                exp_board <= model_board(board_in);
                exp_n     <= model_count(board_in);
                m_rem     <= ROWS + model_count(board_in);
                m_idle    <= 1'b0;
            end
        end else if (!m_done) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done    <= 1'b0;
            m_idle    <= 1'b1;
            exp_score <= (exp_score + model_points(exp_n) > 20'hFFFFF) ? 20'hFFFFF : exp_score + model_points(exp_n);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_idle);
            chk("out_valid", out_valid, m_done);
            chk("score", score, exp_score);
            if (m_done) begin
                chk("board_out", board_out, exp_board);
                chk("lines_cleared", lines_cleared, exp_n);
            end
        end
    end

    task automatic accept(input board_t b);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        board_in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int n_lit);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_latency"}, k, ROWS + n_lit);
        chk({nm, "_model_n"}, exp_n, n_lit);
    endtask

    task automatic leave_done();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    board_t b_empty, b_one, b_four, b_two, b_full;
    board_t e_one, e_four, e_two;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b_empty = '0;
        b_one = '0;  b_one[19*COLS +: COLS] = '1; b_one[18*COLS +: COLS] = 10'h001;
        e_one = '0;  e_one[19*COLS +: COLS] = 10'h001;
        b_four = '0;
        for (int r = 16; r < 20; r++) b_four[r*COLS +: COLS] = '1;
        b_four[15*COLS +: COLS] = 10'h155;
        e_four = '0; e_four[19*COLS +: COLS] = 10'h155;
        b_two = '0;
        b_two[19*COLS +: COLS] = '1; b_two[17*COLS +: COLS] = '1;
        b_two[18*COLS +: COLS] = 10'h001; b_two[16*COLS +: COLS] = 10'h200;
        e_two = '0; e_two[19*COLS +: COLS] = 10'h001; e_two[18*COLS +: COLS] = 10'h200;
        b_full = '1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_board_out", board_out, '0);
        chk("rst_lines", lines_cleared, 5'd0);
        chk("rst_score", score, 20'd0);
        chk_en = 1'b1;

        accept(b_empty);
        chk("empty_model", exp_board, b_empty);
        wait_done("empty", 0);
        leave_done();

        accept(b_one);
        chk("one_model", exp_board, e_one);
        wait_done("one", 1);
`ifdef PETRIS_SCORE_EN
        leave_done();
        @(negedge clk);
        chk("one_score", score, 20'd40);
`else
        leave_done();
`endif

        accept(b_four);
        chk("four_model", exp_board, e_four);
        wait_done("four", 4);
        leave_done();

        accept(b_two);
        chk("two_model", exp_board, e_two);
        wait_done("two", 2);
        leave_done();

        // backpressure: result held while a competing board waits on in_valid
        @(negedge clk);
        board_in = b_one; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 board_in = b_four;
        wait_done("bp", 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 1'b0);
            chk("bp_hold_board", board_out, e_one);
            chk("bp_hold_lines", lines_cleared, 5'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_second_model", exp_board, e_four);
        wait_done("bp_second", 4);
        leave_done();

        // reset on the seventh scan cycle
        accept(b_two);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_board", board_out, '0);
        chk("mid_rst_score", score, 20'd0);
        rst = 1'b0;

        accept(b_full);
        chk("full_model", exp_board, '0);
        wait_done("full", ROWS);
        leave_done();

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Downstream stage of tetrimino generation; consumes the board after a piece has locked.
- Finds every full row, removes it, and compacts the remaining rows toward the bottom.
- Fills the vacated top rows with empty cells and reports the number of lines cleared.
- Multi-cycle row-sequential engine with valid/ready handshakes on input and output.

Parameters:
- COLS, 10, board width in cells.
- ROWS, 20, board height in cells.
- CNT_W, 5, width of lines_cleared; must satisfy 2^CNT_W > ROWS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- board_in  input  ROWS*COLS  locked board. Row r occupies bits [r*COLS +: COLS]; bit c of that slice is column c. Row 0 is the top row, row ROWS-1 the bottom row. 1 = occupied.
- in_valid  input  1  board_in valid.
- in_ready  output  1  engine idle, can accept a board.
- board_out  output  ROWS*COLS  compacted board, same encoding as board_in.
- lines_cleared  output  CNT_W  number of full rows removed.
- out_valid  output  1  board_out and lines_cleared valid.
- out_ready  input  1  consumer accepts the result.
- score  output  20  accumulated score; see Optional Feature.

Behaviour:
- Reset values: in_ready=1, out_valid=0, board_out=0, lines_cleared=0, score=0, state=IDLE.
- Reset mid-operation aborts immediately: the internal board is zeroed, no output is produced, and the next cycle is IDLE.
- Internal state: board register B, which drives board_out directly; read pointer rp and write pointer wp, each clog2(ROWS) bits; counter n, CNT_W bits.

State machine:
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: B<=board_in, rp<=ROWS-1, wp<=ROWS-1, n<=0, go to SCAN.
- SCAN (one row per cycle, bottom to top):
  - If row rp of B is all ones: n<=n+1, wp unchanged.
  - Otherwise: B row wp <= B row rp, then wp<=wp-1. The copy is a no-op when wp==rp.
  - rp<=rp-1.
  - Exit after processing rp==0, exactly ROWS cycles.
  - Exit to FILL if the final count is >0 (include the current row's contribution), otherwise to DONE.
  - Writing row wp while reading row rp is safe because wp>=rp always.
- FILL:
  - Zero B row wp and decrement wp; one row per cycle, exactly n cycles.
  - Go to DONE after clearing row 0.
- DONE:
  - out_valid=1, lines_cleared=n.
  - B and n are held stable while out_ready=0.
  - On out_ready: go to IDLE.

Handshake and timing:
- in_ready is 1 only in IDLE.
- out_valid is 1 only in DONE.
- in_valid during SCAN, FILL or DONE is ignored; no buffering.
- Latency: out_valid first samples high ROWS+N cycles after the accepting edge, where N is the number of cleared rows.
- Back-to-back: earliest next accept is the cycle after the out_valid&out_ready edge.

Boundary cases:
- Empty board: output equals input, N=0.
- Full board: all rows cleared, output all zero, N=ROWS.
- Non-contiguous full rows are all removed; relative order of the surviving rows is preserved.
- Arithmetic is unsigned. wp never underflows because FILL stops at row 0.

Optional Feature:
- Macro: PETRIS_SCORE_EN.
- With the macro defined:
  - On the DONE out_valid&out_ready edge, score += lookup(N): 0→0, 1→40, 2→100, 3→300, 4 or more→1200.
  - Addition saturates at 2^20-1.
  - score is cleared only by rst.
- Without the macro: the score port exists but is constant 0, and no accumulator logic is present.

Decomposition:
- Shared package petris_pkg holds:
  - COLS, ROWS constants.
  - The board vector typedef.
  - The tetrimino type enum used upstream.
  - The score lookup constants.
- One natural sub-module: line_clear_score, the registered saturating accumulator. Instantiate it only under PETRIS_SCORE_EN.
- Row-full detection is an inline reduction-AND.

Test Plan:
- Empty board (all 0) accepted, out_ready=1 → out_valid after 20 cycles; board_out=0, lines_cleared=0, score=0.
- Row 19 all ones; row 18 = 0b0000000001 → out_valid after 21 cycles; row 19 = 0b0000000001, rows 0-18 zero; lines_cleared=1; score=40 with PETRIS_SCORE_EN.
- Rows 16, 17, 18, 19 full; row 15 = 0x155 → out_valid after 24 cycles; row 19 = 0x155, all other rows zero; lines_cleared=4; score=1200.
- Rows 19 and 17 full; row 18 = 0x001; row 16 = 0x200 → row 19=0x001, row 18=0x200, rest zero; lines_cleared=2.
- Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 and a different board → outputs stable, in_ready=0, second board not accepted; accepted the cycle after out_ready.
- rst asserted at SCAN cycle 7 → next cycle IDLE with in_ready=1, out_valid=0, board_out=0, score=0; a new board then processes normally.
